// File: rtl/mpsoc_msi_pkg.sv
// Shared definitions for the MSI AHB3-Lite interconnect: transfer/response
// encodings, master-port FSM states and a one-hot to index helper.
package mpsoc_msi_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Highest set bit wins; callers only ever pass a one-hot or zero vector.
    function automatic int unsigned onehot2int(input logic [31:0] oh);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/mpsoc_msi_master_port_if.sv
// Bus bundle around one MSI master port: AHB master side, broadcast slave
// side, per-slave responses and the arbiter grant/switch handshake.
interface mpsoc_msi_master_port_if #(
    parameter int PLEN   = 64,
    parameter int XLEN   = 64,
    parameter int SLAVES = 5
);
    logic [SLAVES-1:0][PLEN-1:0] slvHADDRBASE;
    logic [SLAVES-1:0][PLEN-1:0] slvHADDRMASK;

    logic            mstHSEL;
    logic [PLEN-1:0] mstHADDR;
    logic [XLEN-1:0] mstHWDATA;
    logic            mstHWRITE;
    logic [2:0]      mstHSIZE;
    logic [2:0]      mstHBURST;
    logic [3:0]      mstHPROT;
    logic [1:0]      mstHTRANS;
    logic            mstHMASTLOCK;
    logic            mstHREADY;
    logic [XLEN-1:0] mstHRDATA;
    logic            mstHREADYOUT;
    logic            mstHRESP;

    logic [SLAVES-1:0] slvHSEL;
    logic [PLEN-1:0]   slvHADDR;
    logic [XLEN-1:0]   slvHWDATA;
    logic              slvHWRITE;
    logic [2:0]        slvHSIZE;
    logic [2:0]        slvHBURST;
    logic [3:0]        slvHPROT;
    logic [1:0]        slvHTRANS;
    logic              slvHMASTLOCK;
    logic              slvHREADY;

    logic [SLAVES-1:0][XLEN-1:0] slvHRDATA;
    logic [SLAVES-1:0]           slvHREADYOUT;
    logic [SLAVES-1:0]           slvHRESP;

    logic [SLAVES-1:0] granted_master;
    logic [SLAVES-1:0] can_switch;

    // Port view: the block is the slave of its AHB master.
    modport slave (
        input  slvHADDRBASE, slvHADDRMASK,
        input  mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHSIZE, mstHBURST,
        input  mstHPROT, mstHTRANS, mstHMASTLOCK, mstHREADY,
        output mstHRDATA, mstHREADYOUT, mstHRESP,
        output slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST,
        output slvHPROT, slvHTRANS, slvHMASTLOCK, slvHREADY,
        input  slvHRDATA, slvHREADYOUT, slvHRESP,
        input  granted_master,
        output can_switch
    );

    modport master (
        output slvHADDRBASE, slvHADDRMASK,
        output mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHSIZE, mstHBURST,
        output mstHPROT, mstHTRANS, mstHMASTLOCK, mstHREADY,
        input  mstHRDATA, mstHREADYOUT, mstHRESP,
        input  slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST,
        input  slvHPROT, slvHTRANS, slvHMASTLOCK, slvHREADY,
        output slvHRDATA, slvHREADYOUT, slvHRESP,
        output granted_master,
        input  can_switch
    );

endinterface

// File: rtl/mpsoc_msi_address_decoder.sv
// Base/mask address match against the slave map; lowest matching index wins.
module mpsoc_msi_address_decoder #(
    parameter int PLEN   = 64,
    parameter int SLAVES = 5
) (
    input  logic [PLEN-1:0]              addr,
    input  logic [SLAVES-1:0][PLEN-1:0]  base,
    input  logic [SLAVES-1:0][PLEN-1:0]  mask,
    output logic [SLAVES-1:0]            sel,
    output logic                         no_match
);

    logic found;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int s = 0; s < SLAVES; s++) begin
            if (!found && ((addr & mask[s]) == (base[s] & mask[s]))) begin
                sel[s] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign no_match = ~found;

endmodule

// File: rtl/mpsoc_msi_master_port.sv
// Per-master front end: decodes address phases, holds them until the target
// arbiter grants, muxes slave responses back and answers unmapped accesses.
module mpsoc_msi_master_port
    import mpsoc_msi_pkg::*;
#(
    parameter int PLEN   = 64,
    parameter int XLEN   = 64,
    parameter int SLAVES = 5
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    mpsoc_msi_master_port_if.slave    bus
);

    localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    state_t          state, state_nxt;
    logic [SW-1:0]   ds, ds_nxt;
    logic [SW-1:0]   hs, hs_nxt;
    logic            data_lock, data_lock_nxt;
    logic            capture;

    logic [PLEN-1:0] h_addr;
    logic            h_write;
    logic [2:0]      h_size;
    logic [2:0]      h_burst;
    logic [3:0]      h_prot;
    logic [1:0]      h_trans;
    logic            h_lock;

    logic [SLAVES-1:0] dec_sel;
    logic              dec_miss;
    logic [SW-1:0]     dec_idx;
    logic              accept;
    logic [SLAVES-1:0] ds_oh, hs_oh;
    logic [SLAVES-1:0] next_same;
    logic [SLAVES-1:0] pin;
    logic [XLEN-1:0]   rdata;

    mpsoc_msi_address_decoder #(
        .PLEN   (PLEN),
        .SLAVES (SLAVES)
    ) u_dec (
        .addr     (bus.mstHADDR),
        .base     (bus.slvHADDRBASE),
        .mask     (bus.slvHADDRMASK),
        .sel      (dec_sel),
        .no_match (dec_miss)
    );

    assign dec_idx = SW'(onehot2int(32'(dec_sel)));
    assign accept  = bus.mstHSEL & bus.mstHREADY & bus.mstHTRANS[1];
    assign ds_oh   = SLAVES'(1) << ds;
    assign hs_oh   = SLAVES'(1) << hs;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            ds        <= '0;
            hs        <= '0;
            data_lock <= 1'b0;
            h_addr    <= '0;
            h_write   <= 1'b0;
            h_size    <= '0;
            h_burst   <= '0;
            h_prot    <= '0;
            h_trans   <= HTRANS_IDLE;
            h_lock    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ds        <= ds_nxt;
            hs        <= hs_nxt;
            data_lock <= data_lock_nxt;
            if (capture) begin
                h_addr  <= bus.mstHADDR;
                h_write <= bus.mstHWRITE;
                h_size  <= bus.mstHSIZE;
                h_burst <= bus.mstHBURST;
                h_prot  <= bus.mstHPROT;
                h_trans <= bus.mstHTRANS;
                h_lock  <= bus.mstHMASTLOCK;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        ds_nxt        = ds;
        hs_nxt        = hs;
        data_lock_nxt = data_lock;
        capture       = 1'b0;
        case (state)
            ST_IDLE, ST_DATA: begin
                if (accept) begin
                    if (dec_miss) begin
                        state_nxt = ST_ERR1;
                    end else if (bus.granted_master[dec_idx]) begin
                        state_nxt     = ST_DATA;
                        ds_nxt        = dec_idx;
                        data_lock_nxt = bus.mstHMASTLOCK;
                    end else begin
                        state_nxt = ST_WAIT;
                        hs_nxt    = dec_idx;
                        capture   = 1'b1;
                    end
                end else if (state == ST_DATA && bus.slvHREADYOUT[ds]) begin
                    state_nxt = ST_IDLE;
                end
            end
            // A dropped grant simply keeps us here.
            ST_WAIT: begin
                if (bus.granted_master[hs] && bus.slvHREADYOUT[hs]) begin
                    state_nxt     = ST_DATA;
                    ds_nxt        = hs;
                    data_lock_nxt = h_lock;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.slvHSEL      = bus.mstHSEL ? dec_sel : '0;
        bus.slvHADDR     = bus.mstHADDR;
        bus.slvHWRITE    = bus.mstHWRITE;
        bus.slvHSIZE     = bus.mstHSIZE;
        bus.slvHBURST    = bus.mstHBURST;
        bus.slvHPROT     = bus.mstHPROT;
        bus.slvHTRANS    = bus.mstHSEL ? bus.mstHTRANS : HTRANS_IDLE;
        bus.slvHMASTLOCK = bus.mstHMASTLOCK;
        rdata            = '0;
        bus.mstHREADYOUT = 1'b1;
        bus.mstHRESP     = HRESP_OKAY;
        case (state)
            ST_WAIT: begin
                bus.slvHSEL      = hs_oh;
                bus.slvHADDR     = h_addr;
                bus.slvHWRITE    = h_write;
                bus.slvHSIZE     = h_size;
                bus.slvHBURST    = h_burst;
                bus.slvHPROT     = h_prot;
                // The arbiter may have switched away mid-burst, so restart it.
                bus.slvHTRANS    = (h_trans == HTRANS_SEQ) ? HTRANS_NONSEQ : h_trans;
                bus.slvHMASTLOCK = h_lock;
                bus.mstHREADYOUT = 1'b0;
            end
            ST_DATA: begin
                rdata            = bus.slvHRDATA[ds];
                bus.mstHREADYOUT = bus.slvHREADYOUT[ds];
                bus.mstHRESP     = bus.slvHRESP[ds];
            end
            ST_ERR1: begin
                bus.slvHSEL      = '0;
                bus.slvHTRANS    = HTRANS_IDLE;
                bus.mstHREADYOUT = 1'b0;
                bus.mstHRESP     = HRESP_ERROR;
            end
            ST_ERR2: begin
                bus.slvHSEL      = '0;
                bus.slvHTRANS    = HTRANS_IDLE;
                bus.mstHREADYOUT = 1'b1;
                bus.mstHRESP     = HRESP_ERROR;
            end
            default: ;
        endcase
    end

    assign bus.mstHRDATA = rdata;
    assign bus.slvHWDATA = bus.mstHWDATA;
    assign bus.slvHREADY = bus.mstHREADYOUT;

    // Keep the arbiter on us through a locked phase or a burst continuing to the same slave.
    assign next_same = (bus.mstHSEL && (bus.mstHTRANS == HTRANS_SEQ || bus.mstHTRANS == HTRANS_BUSY))
                       ? dec_sel : '0;

    always_comb begin
        pin = '0;
        if (state == ST_DATA && (data_lock || next_same[ds]))
            pin = ds_oh;
        else if (state == ST_WAIT && (h_lock || next_same[hs]))
            pin = hs_oh;
        bus.can_switch = ~pin;
    end

endmodule

// File: tb/tb_mpsoc_msi_master_port.sv
// Directed bench for the MSI master port with a response scoreboard.
module tb_mpsoc_msi_master_port;
    import mpsoc_msi_pkg::*;

    localparam int PLEN   = 64;
    localparam int XLEN   = 64;
    localparam int SLAVES = 5;
    localparam logic [63:0] MASK = 64'hFFFF_FFFF_F000_0000;

    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    mpsoc_msi_master_port_if #(.PLEN(PLEN), .XLEN(XLEN), .SLAVES(SLAVES)) bus ();

    mpsoc_msi_master_port #(.PLEN(PLEN), .XLEN(XLEN), .SLAVES(SLAVES)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus.slave)
    );

    // Single-master bus: the master sees its own ready.
    assign bus.mstHREADY = bus.mstHREADYOUT;

    typedef struct {
        logic [63:0] rdata;
        logic        resp;
    } rsp_t;
    rsp_t sb[$];

    int checks   = 0;
    int failures = 0;

    function automatic logic [63:0] rd_pat(input int s);
        return 64'hD000_0000_0000_0000 | (64'(s) * 64'h1111);
    endfunction

    function automatic logic [63:0] base_of(input int s);
        return 64'(s + 1) << 28;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        @(negedge HCLK);
    endtask

    task automatic drive(input logic sel, input logic [63:0] addr, input logic [1:0] trans,
                         input logic write, input logic lock, input logic [2:0] burst);
        bus.mstHSEL      = sel;
        bus.mstHADDR     = addr;
        bus.mstHTRANS    = trans;
        bus.mstHWRITE    = write;
        bus.mstHMASTLOCK = lock;
        bus.mstHBURST    = burst;
        bus.mstHSIZE     = 3'b011;
        bus.mstHPROT     = 4'b0011;
    endtask

    task automatic idle_bus();
        drive(1'b0, 64'h0, HTRANS_IDLE, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic expect_rsp(input int s);
        rsp_t e;
        e.rdata = rd_pat(s);
        e.resp  = HRESP_OKAY;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        rsp_t e;
        e = sb.pop_front();
        chk({tag, "_ready"}, 64'(bus.mstHREADYOUT), 64'd1);
        chk({tag, "_rdata"}, bus.mstHRDATA, e.rdata);
        chk({tag, "_resp"},  64'(bus.mstHRESP), 64'(e.resp));
    endtask

    initial begin
        HRESET = 1'b1;
        idle_bus();
        bus.mstHWDATA      = '0;
        bus.granted_master = '0;
        bus.slvHREADYOUT   = '1;
        bus.slvHRESP       = '0;
        for (int s = 0; s < SLAVES; s++) begin
            bus.slvHADDRBASE[s] = base_of(s);
            bus.slvHADDRMASK[s] = MASK;
            bus.slvHRDATA[s]    = rd_pat(s);
        end

        // Reset state
        next_cyc();
        settle();
        chk("rst_ready",  64'(bus.mstHREADYOUT), 64'd1);
        chk("rst_resp",   64'(bus.mstHRESP), 64'd0);
        chk("rst_rdata",  bus.mstHRDATA, 64'd0);
        chk("rst_hsel",   64'(bus.slvHSEL), 64'd0);
        chk("rst_htrans", 64'(bus.slvHTRANS), 64'(HTRANS_IDLE));
        chk("rst_cansw",  64'(bus.can_switch), 64'h1F);

        // Granted read to slave 2
        next_cyc();
        HRESET = 1'b0;
        bus.granted_master = 5'b00100;
        drive(1'b1, base_of(2) + 64'h10, HTRANS_NONSEQ, 1'b0, 1'b0, 3'b000);
        expect_rsp(2);
        settle();
        chk("gr_hsel",  64'(bus.slvHSEL), 64'b00100);
        chk("gr_haddr", bus.slvHADDR, base_of(2) + 64'h10);
        next_cyc();
        idle_bus();
        settle();
        pop_chk("gr_data");
        chk("gr_cansw", 64'(bus.can_switch), 64'h1F);

        // Ungranted write to slave 1: three ungranted cycles, then the grant cycle
        next_cyc();
        bus.granted_master = 5'b00000;
        drive(1'b1, base_of(1) + 64'h40, HTRANS_NONSEQ, 1'b1, 1'b0, 3'b000);
        expect_rsp(1);
        settle();
        chk("uw_hsel_addr", 64'(bus.slvHSEL), 64'b00010);
        for (int c = 0; c < 4; c++) begin
            next_cyc();
            idle_bus();
            if (c == 3) bus.granted_master = 5'b00010;
            settle();
            chk($sformatf("uw_wait%0d_ready", c), 64'(bus.mstHREADYOUT), 64'd0);
            chk($sformatf("uw_wait%0d_haddr", c), bus.slvHADDR, base_of(1) + 64'h40);
            chk($sformatf("uw_wait%0d_hsel", c), 64'(bus.slvHSEL), 64'b00010);
        end
        chk("uw_hwrite", 64'(bus.slvHWRITE), 64'd1);
        next_cyc();
        bus.mstHWDATA = 64'hCAFE_F00D_1234_5678;
        settle();
        chk("uw_hwdata", bus.slvHWDATA, 64'hCAFE_F00D_1234_5678);
        pop_chk("uw_data");

        // Unmapped address: two-cycle ERROR, phase in second cycle ignored
        next_cyc();
        drive(1'b1, 64'h9000_0000, HTRANS_NONSEQ, 1'b0, 1'b0, 3'b000);
        settle();
        chk("um_hsel", 64'(bus.slvHSEL), 64'd0);
        next_cyc();
        idle_bus();
        settle();
        chk("um_err1_ready", 64'(bus.mstHREADYOUT), 64'd0);
        chk("um_err1_resp",  64'(bus.mstHRESP), 64'd1);
        next_cyc();
        bus.granted_master = 5'b00100;
        drive(1'b1, base_of(2), HTRANS_NONSEQ, 1'b0, 1'b0, 3'b000);
        settle();
        chk("um_err2_ready", 64'(bus.mstHREADYOUT), 64'd1);
        chk("um_err2_resp",  64'(bus.mstHRESP), 64'd1);
        chk("um_err2_hsel",  64'(bus.slvHSEL), 64'd0);
        next_cyc();
        idle_bus();
        settle();
        chk("um_idle_ready", 64'(bus.mstHREADYOUT), 64'd1);
        chk("um_idle_resp",  64'(bus.mstHRESP), 64'd0);
        chk("um_idle_rdata", bus.mstHRDATA, 64'd0);

        // Locked INCR4 burst to slave 0
        next_cyc();
        bus.granted_master = 5'b00001;
        drive(1'b1, base_of(0), HTRANS_NONSEQ, 1'b0, 1'b1, 3'b011);
        expect_rsp(0);
        for (int b = 0; b < 4; b++) begin
            next_cyc();
            if (b < 3) begin
                drive(1'b1, base_of(0) + 64'(8 * (b + 1)), HTRANS_SEQ, 1'b0, 1'b1, 3'b011);
                expect_rsp(0);
            end else begin
                idle_bus();
            end
            settle();
            chk($sformatf("lk_beat%0d_cansw0", b), 64'(bus.can_switch[0]), 64'd0);
            pop_chk($sformatf("lk_beat%0d", b));
        end
        next_cyc();
        settle();
        chk("lk_done_cansw", 64'(bus.can_switch), 64'h1F);

        // Burst continuing SEQ into ungranted slave 3, then reset in WAIT
        next_cyc();
        bus.granted_master = 5'b00100;
        drive(1'b1, base_of(2) + 64'hFF8, HTRANS_NONSEQ, 1'b0, 1'b0, 3'b001);
        expect_rsp(2);
        next_cyc();
        drive(1'b1, base_of(3), HTRANS_SEQ, 1'b0, 1'b0, 3'b001);
        settle();
        chk("sp_pass_htrans", 64'(bus.slvHTRANS), 64'(HTRANS_SEQ));
        chk("sp_pass_hsel",   64'(bus.slvHSEL), 64'b01000);
        pop_chk("sp_data2");
        next_cyc();
        settle();
        chk("sp_wait_htrans", 64'(bus.slvHTRANS), 64'(HTRANS_NONSEQ));
        chk("sp_wait_hsel",   64'(bus.slvHSEL), 64'b01000);
        chk("sp_wait_haddr",  bus.slvHADDR, base_of(3));
        chk("sp_wait_ready",  64'(bus.mstHREADYOUT), 64'd0);
        next_cyc();
        HRESET = 1'b1;
        idle_bus();
        bus.granted_master = '0;
        next_cyc();
        settle();
        chk("rw_hsel",   64'(bus.slvHSEL), 64'd0);
        chk("rw_ready",  64'(bus.mstHREADYOUT), 64'd1);
        chk("rw_htrans", 64'(bus.slvHTRANS), 64'(HTRANS_IDLE));
        next_cyc();
        HRESET = 1'b0;

        // Overlapping map: lowest matching index wins; IDLE/BUSY get zero-wait OKAY
        bus.slvHADDRMASK[3] = '0;
        drive(1'b1, base_of(4) + 64'h20, HTRANS_IDLE, 1'b0, 1'b0, 3'b000);
        settle();
        chk("pr_hsel",  64'(bus.slvHSEL), 64'b01000);
        chk("pr_ready", 64'(bus.mstHREADYOUT), 64'd1);
        next_cyc();
        drive(1'b1, base_of(4) + 64'h20, HTRANS_BUSY, 1'b0, 1'b0, 3'b000);
        settle();
        chk("by_ready", 64'(bus.mstHREADYOUT), 64'd1);
        chk("by_resp",  64'(bus.mstHRESP), 64'd0);
        next_cyc();
        idle_bus();
        settle();
        chk("by_nostate_rdata", bus.mstHRDATA, 64'd0);
        chk("by_nostate_ready", 64'(bus.mstHREADYOUT), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
